sensor_pulse_gen: RTL and testbench
===================================

Name: sensor_pulse_gen

Overview:
- Parametrised synthetic sensor stimulus generator for bench and FPGA bring-up of the bicycle computer core.
- Replaces fixed fork/crank pulse counters with NCH independent channels. Each channel has a programmable period, pulse width and mode: off, continuous, speed sweep or single shot.
- Also produces the heartbeat LED toggle.
- Sits beside comp_core in the top level. Its nPulse outputs drive nFork/nCrank and any further sensor inputs.

Parameters:
- NCH, 2, number of pulse channels (1..8).
- CW, 14, counter/period/width/step width in bits.
- DEF_PERIOD, {14'd7680,14'd4941}, packed NCH*CW reset base periods; ch0 in the LSBs.
- DEF_WIDTH, {14'd51,14'd26}, packed NCH*CW reset widths.
- DEF_MODE, 2'b01 per channel, reset mode (CONT).
- HB_DIV, 12800, heartbeat half-period in cycles minus one.

Ports:
- Reset  in  1  async active-low reset.
- clk_12_8M__12_8K  in  1  generator clock (nominal 12.8 kHz).
- cfg_we  in  1  config write strobe, one cycle per write.
- cfg_ch  in  3  target channel; writes with cfg_ch>=NCH are ignored.
- cfg_addr  in  3  register select: 0 PERIOD, 1 WIDTH, 2 MINP, 3 STEP, 4 MODE; 5..7 ignored.
- cfg_data  in  CW  write data; MODE uses bits [1:0].
- nPulse  out  NCH  active-low sensor pulses.
- shot_done  out  NCH  one-cycle strobe at the end of a single-shot period.
- sweep_dir  out  NCH  1 = period currently decreasing.
- pulse_led  out  1  heartbeat toggle.

Behaviour:
- Reset is Reset, asynchronous, active-low, on clock clk_12_8M__12_8K.
- Reset values: all counters 0; base/current period = DEF_PERIOD; width = DEF_WIDTH; MINP = base; STEP = 0; mode = DEF_MODE; sweep_dir = 1; nPulse = all 1; shot_done = 0; pulse_led = 0.
- Per-channel counter cnt runs 0..Pcur. Wrap occurs when cnt==Pcur, and cnt returns to 0, giving Pcur+1 cycles per period.
- nPulse[i] = 0 when the mode is not OFF, Pcur != 0 and cnt <= Weff; otherwise 1. The output is registered, so there is one cycle of latency from cnt.
- Weff = min(WIDTH, Pcur-1). This guarantees at least one idle cycle per period. WIDTH=0 gives a 1-cycle pulse.
- Pcur == 0: cnt is held at 0 and nPulse is held at 1, whatever the mode.
- PERIOD and WIDTH writes go to shadow registers. The active copies load from the shadows at the next wrap.
- A write landing on the same cycle as a wrap is used by that wrap (bypass).
- MINP and STEP writes take effect immediately.
- Modes:
  - OFF (0): cnt is held at 0 and nPulse is 1.
  - CONT (1): fixed period Pcur = base.
  - SWEEP (2): at each wrap, if sweep_dir=1, Pcur_next = Pcur-STEP. If that value is <= MINP (or underflows), Pcur_next = MINP and sweep_dir becomes 0.
  - SWEEP, sweep_dir=0: Pcur_next = Pcur+STEP. If that value is >= base (or overflows CW), Pcur_next = base and sweep_dir becomes 1.
  - SWEEP edge cases: STEP=0 or MINP>=base degenerates to CONT at base.
  - SHOT (3): runs exactly one period from cnt=0. At its wrap, shot_done pulses for 1 cycle, mode becomes OFF and cnt returns to 0.
- MODE write, including rewriting the same mode:
  - cnt is forced to 0 and Pcur is reloaded from base (shadow included).
  - sweep_dir is set to 1 and shot_done is cleared.
  - The new mode takes effect from the next cycle, so a SHOT can be retriggered.
- Channels are fully independent. A write to one channel never disturbs another.
- Heartbeat: hb counts 0..HB_DIV, then wraps to 0. pulse_led toggles on the cycle hb==HB_DIV.
- Reset asserted mid-operation returns every register to its reset value immediately, with no pending-write carry-over.

Decomposition:
- Package spg_pkg holds:
  - the mode enum spg_mode_e {SPG_OFF, SPG_CONT, SPG_SWEEP, SPG_SHOT};
  - the register address localparams SPG_A_PERIOD..SPG_A_MODE;
  - the CW default.
- Sub-module spg_chan implements one channel: registers, counter, sweep and shot logic. The top instantiates NCH copies in a generate loop, decodes cfg_ch/cfg_addr into per-channel write enables, and holds the heartbeat counter.

Test Plan:
- Reset defaults:
  - ch0 nPulse low for cycles 0..26 of each 4942-cycle period.
  - ch1 low for 52 of every 7681 cycles.
  - pulse_led toggles every 12801 cycles.
- PERIOD=99, WIDTH=9 written mid-period -> old period completes, then exactly 10 low / 90 high cycles repeat; write on the wrap cycle -> new timing applies immediately.
- SWEEP, base=100, MINP=40, STEP=20 -> successive period lengths (cycles) 101,81,61,41,61,81,101,81...; sweep_dir flips at 40 and at 100.
- SHOT, PERIOD=9, WIDTH=2 -> a single 3-cycle low pulse; shot_done high 1 cycle after cycle 10; then nPulse stays 1. Rewriting SHOT retriggers.
- Edge values:
  - WIDTH=50 with PERIOD=10 -> low 10 cycles, high 1 per period.
  - PERIOD=0 -> nPulse held 1.
  - cfg_ch=5 with NCH=2 -> no effect.
- Reset pulsed mid-sweep -> all outputs return immediately to reset values; after release, defaults resume from cnt=0.

Source files
------------

// File: rtl/sensor_pulse_gen_pkg.sv
// rtl/sensor_pulse_gen_pkg.sv - shared types and constants for the sensor pulse generator
package spg_pkg;

  localparam int SPG_CW = 14;

  typedef enum logic [1:0] {
    SPG_OFF   = 2'd0,
    SPG_CONT  = 2'd1,
    SPG_SWEEP = 2'd2,
    SPG_SHOT  = 2'd3
  } spg_mode_e;

  localparam logic [2:0] SPG_A_PERIOD = 3'd0;
  localparam logic [2:0] SPG_A_WIDTH  = 3'd1;
  localparam logic [2:0] SPG_A_MINP   = 3'd2;
  localparam logic [2:0] SPG_A_STEP   = 3'd3;
  localparam logic [2:0] SPG_A_MODE   = 3'd4;

endpackage

// File: rtl/sensor_pulse_gen_if.sv
// rtl/sensor_pulse_gen_if.sv - configuration write bus for the sensor pulse generator
interface sensor_pulse_gen_if
  import spg_pkg::*;
#(
  parameter int CW = SPG_CW
);

  logic          cfg_we;
  logic [2:0]    cfg_ch;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_data;

  modport master (output cfg_we, cfg_ch, cfg_addr, cfg_data);
  modport slave  (input  cfg_we, cfg_ch, cfg_addr, cfg_data);

endinterface

// File: rtl/sensor_pulse_gen_chan.sv
// rtl/sensor_pulse_gen_chan.sv - one pulse channel: shadowed period/width, counter, sweep and single shot
module spg_chan
  import spg_pkg::*;
#(
  parameter int            CW         = SPG_CW,
  parameter logic [CW-1:0] DEF_PERIOD = '0,
  parameter logic [CW-1:0] DEF_WIDTH  = '0,
  parameter logic [1:0]    DEF_MODE   = 2'b01
) (
  input  logic          Reset,
  input  logic          clk_12_8M__12_8K,
  input  logic          i_we,
  input  logic [2:0]    i_addr,
  input  logic [CW-1:0] i_data,
  output logic          o_npulse,
  output logic          o_shot_done,
  output logic          o_sweep_dir
);

  logic [CW-1:0] r_cnt, r_pcur, r_width, r_per_sh, r_wid_sh, r_minp, r_step;
  spg_mode_e     r_mode;
  logic          r_dir, r_npulse, r_done;

  logic          w_we_per, w_we_wid, w_we_minp, w_we_step, w_we_mode;
  logic [CW-1:0] w_per_sh, w_wid_sh, w_minp, w_step, w_weff, w_sw_pcur;
  logic [CW:0]   w_dec, w_inc;
  logic          w_wrap, w_low, w_sw_dir;

  assign w_we_per  = i_we && (i_addr == SPG_A_PERIOD);
  assign w_we_wid  = i_we && (i_addr == SPG_A_WIDTH);
  assign w_we_minp = i_we && (i_addr == SPG_A_MINP);
  assign w_we_step = i_we && (i_addr == SPG_A_STEP);
  assign w_we_mode = i_we && (i_addr == SPG_A_MODE);

  // Same-cycle writes bypass into the wrap so the new timing is not lost for a period.
  assign w_per_sh = w_we_per  ? i_data : r_per_sh;
  assign w_wid_sh = w_we_wid  ? i_data : r_wid_sh;
  assign w_minp   = w_we_minp ? i_data : r_minp;
  assign w_step   = w_we_step ? i_data : r_step;

  assign w_wrap = (r_mode != SPG_OFF) && (r_cnt == r_pcur);
  assign w_weff = (r_width < r_pcur) ? r_width : r_pcur - CW'(1);
  assign w_low  = (r_mode != SPG_OFF) && (r_pcur != '0) && (r_cnt <= w_weff);

  assign w_dec = {1'b0, r_pcur} - {1'b0, w_step};
  assign w_inc = {1'b0, r_pcur} + {1'b0, w_step};

  always_comb begin
    w_sw_pcur = r_pcur;
    w_sw_dir  = r_dir;
    if ((w_step == '0) || (w_minp >= w_per_sh)) begin
      w_sw_pcur = w_per_sh;
      w_sw_dir  = 1'b1;
    end else if (r_dir) begin
      if (w_dec[CW] || (w_dec[CW-1:0] <= w_minp)) begin
        w_sw_pcur = w_minp;
        w_sw_dir  = 1'b0;
      end else begin
        w_sw_pcur = w_dec[CW-1:0];
      end
    end else begin
      if (w_inc >= {1'b0, w_per_sh}) begin
        w_sw_pcur = w_per_sh;
        w_sw_dir  = 1'b1;
      end else begin
        w_sw_pcur = w_inc[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk_12_8M__12_8K or negedge Reset) begin
    if (!Reset) begin
      r_cnt    <= '0;
      r_pcur   <= DEF_PERIOD;
      r_width  <= DEF_WIDTH;
      r_per_sh <= DEF_PERIOD;
      r_wid_sh <= DEF_WIDTH;
      r_minp   <= DEF_PERIOD;
      r_step   <= '0;
      r_mode   <= spg_mode_e'(DEF_MODE);
      r_dir    <= 1'b1;
      r_npulse <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_npulse <= ~w_low;
      if (w_we_per)  r_per_sh <= i_data;
      if (w_we_wid)  r_wid_sh <= i_data;
      if (w_we_minp) r_minp   <= i_data;
      if (w_we_step) r_step   <= i_data;
      if (w_we_mode) begin
        r_mode  <= spg_mode_e'(i_data[1:0]);
        r_cnt   <= '0;
        r_pcur  <= r_per_sh;
        r_width <= r_wid_sh;
        r_dir   <= 1'b1;
      end else if (r_mode == SPG_OFF) begin
        r_cnt <= '0;
      end else if (w_wrap) begin
        // A zero period wraps every cycle, which holds cnt at 0 yet still picks up new shadows.
        r_cnt   <= '0;
        r_width <= w_wid_sh;
        case (r_mode)
          SPG_SWEEP: begin
            r_pcur <= w_sw_pcur;
            r_dir  <= w_sw_dir;
          end
          SPG_SHOT: begin
            r_pcur <= w_per_sh;
            r_mode <= SPG_OFF;
            r_done <= 1'b1;
          end
          default: r_pcur <= w_per_sh;
        endcase
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_npulse    = r_npulse;
  assign o_shot_done = r_done;
  assign o_sweep_dir = r_dir;

endmodule

// File: rtl/sensor_pulse_gen.sv
// rtl/sensor_pulse_gen.sv - multi-channel synthetic sensor pulse generator with heartbeat LED
module sensor_pulse_gen
  import spg_pkg::*;
#(
  parameter int                NCH        = 2,
  parameter int                CW         = SPG_CW,
  parameter logic [NCH*CW-1:0] DEF_PERIOD = {14'd7680, 14'd4941},
  parameter logic [NCH*CW-1:0] DEF_WIDTH  = {14'd51, 14'd26},
  parameter logic [NCH*2-1:0]  DEF_MODE   = {NCH{2'b01}},
  parameter int                HB_DIV     = 12800
) (
  input  logic               Reset,
  input  logic               clk_12_8M__12_8K,
  sensor_pulse_gen_if.slave  cfg,
  output logic [NCH-1:0]     nPulse,
  output logic [NCH-1:0]     shot_done,
  output logic [NCH-1:0]     sweep_dir,
  output logic               pulse_led
);

  localparam int HBW = $clog2(HB_DIV + 1);

  logic [NCH-1:0] w_ch_we;
  logic [HBW-1:0] r_hb;
  logic           r_led;

  // Channel numbers at or above NCH match no instance, so those writes fall away.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_ch_we[g] = cfg.cfg_we && (cfg.cfg_ch == 3'(g));

    spg_chan #(
      .CW        (CW),
      .DEF_PERIOD(DEF_PERIOD[g*CW +: CW]),
      .DEF_WIDTH (DEF_WIDTH[g*CW +: CW]),
      .DEF_MODE  (DEF_MODE[g*2 +: 2])
    ) u_chan (
      .Reset           (Reset),
      .clk_12_8M__12_8K(clk_12_8M__12_8K),
      .i_we            (w_ch_we[g]),
      .i_addr          (cfg.cfg_addr),
      .i_data          (cfg.cfg_data),
      .o_npulse        (nPulse[g]),
      .o_shot_done     (shot_done[g]),
      .o_sweep_dir     (sweep_dir[g])
    );
  end

  always_ff @(posedge clk_12_8M__12_8K or negedge Reset) begin
    if (!Reset) begin
      r_hb  <= '0;
      r_led <= 1'b0;
    end else if (r_hb == HBW'(HB_DIV)) begin
      r_hb  <= '0;
      r_led <= ~r_led;
    end else begin
      r_hb <= r_hb + HBW'(1);
    end
  end

  assign pulse_led = r_led;

endmodule

// File: tb/tb_sensor_pulse_gen.sv
// tb/tb_sensor_pulse_gen.sv - scoreboard bench for sensor_pulse_gen pulse timing, sweep, shot and reset
module tb_sensor_pulse_gen;
  import spg_pkg::*;

  typedef struct {
    int low;
    int per;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] nPulse, shot_done, sweep_dir;
  logic       pulse_led;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   sync_gen[2];
  int   seen_gen[2];

  sensor_pulse_gen_if #(.CW(14)) cfg_if ();

  sensor_pulse_gen dut (
    .Reset           (rst_n),
    .clk_12_8M__12_8K(clk),
    .cfg             (cfg_if),
    .nPulse          (nPulse),
    .shot_done       (shot_done),
    .sweep_dir       (sweep_dir),
    .pulse_led       (pulse_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cfg_wr(input int ch, input logic [2:0] addr, input int data);
    @(negedge clk);
    cfg_if.cfg_we   = 1'b1;
    cfg_if.cfg_ch   = 3'(ch);
    cfg_if.cfg_addr = addr;
    cfg_if.cfg_data = 14'(data);
    @(negedge clk);
    cfg_if.cfg_we   = 1'b0;
  endtask

  task automatic push(input int ch, input int low, input int per, input int n);
    exp_t e;
    e.low = low;
    e.per = per;
    for (int i = 0; i < n; i++) begin
      if (ch == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic wait_drain(input int ch, input int budget, input string tag);
    int n;
    n = 0;
    while (((ch == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (ch == 0) ? q0.size() : q1.size(), 0);
    if (ch == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic shot_run(input string tag);
    int lows, first_low, done_idx, done_n;
    cfg_wr(0, SPG_A_MODE, 3);
    lows = 0; first_low = -1; done_idx = -1; done_n = 0;
    for (int k = 0; k < 31; k++) begin
      if (k > 0) @(negedge clk);
      if (nPulse[0] === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = k;
      end
      if (shot_done[0] === 1'b1) begin
        done_n++;
        done_idx = k;
      end
    end
    chk({tag, "_lows"}, lows, 3);
    chk({tag, "_first_low"}, first_low, 1);
    chk({tag, "_done_idx"}, done_idx, 10);
    chk({tag, "_done_n"}, done_n, 1);
  endtask

  // Pulse monitor: on each falling edge, the previous pulse's low length and fall-to-fall period are scored.
  initial begin
    int   t;
    bit   prev[2];
    bit   have[2];
    int   fall_t[2];
    int   lows[2];
    logic cur;
    exp_t e;
    t = 0;
    for (int c = 0; c < 2; c++) begin
      prev[c] = 1'b1; have[c] = 1'b0; fall_t[c] = 0; lows[c] = 0; seen_gen[c] = 0;
    end
    forever begin
      @(negedge clk);
      t++;
      for (int c = 0; c < 2; c++) begin
        cur = nPulse[c];
        if (sync_gen[c] != seen_gen[c]) begin
          seen_gen[c] = sync_gen[c];
          have[c] = 1'b0;
        end
        if (prev[c] && cur === 1'b0) begin
          if (have[c]) begin
            if (c == 0 && q0.size() > 0) begin
              e = q0.pop_front();
              chk("ch0_low", lows[c], e.low);
              chk("ch0_period", t - fall_t[c], e.per);
            end else if (c == 1 && q1.size() > 0) begin
              e = q1.pop_front();
              chk("ch1_low", lows[c], e.low);
              chk("ch1_period", t - fall_t[c], e.per);
            end
          end
          have[c] = 1'b1;
          fall_t[c] = t;
          lows[c] = 0;
        end
        if (cur === 1'b0) lows[c]++;
        prev[c] = (cur !== 1'b0);
      end
    end
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, k1, k2, n, lows;
    logic pl, p;
    sync_gen[0] = 0;
    sync_gen[1] = 0;
    rst_n = 1'b0;
    cfg_if.cfg_we = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_addr = '0;
    cfg_if.cfg_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_npulse", nPulse, 2'b11);
    chk("rst_shot_done", shot_done, 2'b00);
    chk("rst_sweep_dir", sweep_dir, 2'b11);
    chk("rst_led", pulse_led, 1'b0);

    // Defaults: ch0 27 low of 4942, ch1 52 low of 7681, LED half-period 12801
    push(0, 27, 4942, 2);
    push(1, 52, 7681, 1);
    rst_n = 1'b1;
    pl = pulse_led; k1 = -1; k2 = -1;
    for (k = 1; k <= 26000 && k2 < 0; k++) begin
      @(negedge clk);
      if (pulse_led !== pl) begin
        if (k1 < 0) k1 = k;
        else k2 = k;
        pl = pulse_led;
      end
    end
    chk("led_first", k1, 12801);
    chk("led_half", k2 - k1, 12801);
    wait_drain(0, 10, "def_ch0_drain");
    wait_drain(1, 10, "def_ch1_drain");

    // PERIOD/WIDTH written mid-period: old period completes, then 10 low / 100 total
    sync_gen[0]++;
    @(negedge clk);
    push(0, 27, 4942, 1);
    push(0, 10, 100, 3);
    p = nPulse[0]; n = 0;
    do begin
      p = nPulse[0];
      @(negedge clk);
      n++;
    end while (!(p === 1'b1 && nPulse[0] === 1'b0) && n < 6000);
    chk("mid_fall_seen", n < 6000, 1);
    repeat (5) @(negedge clk);
    cfg_wr(0, SPG_A_PERIOD, 99);
    cfg_wr(0, SPG_A_WIDTH, 9);
    wait_drain(0, 6000, "mid_drain");

    // ch1: OFF holds high; PERIOD written exactly on the wrap cycle applies to the next period
    cfg_wr(1, SPG_A_MODE, 0);
    repeat (3) @(negedge clk);
    chk("off_high", nPulse[1], 1'b1);
    cfg_wr(1, SPG_A_PERIOD, 49);
    cfg_wr(1, SPG_A_WIDTH, 4);
    sync_gen[1]++;
    @(negedge clk);
    push(1, 5, 50, 1);
    push(1, 5, 20, 2);
    cfg_wr(1, SPG_A_MODE, 1);
    repeat (48) @(negedge clk);
    cfg_wr(1, SPG_A_PERIOD, 19);
    wait_drain(1, 300, "wrapwr_drain");

    // Writes to a channel number beyond NCH leave ch1 running untouched
    push(1, 5, 20, 3);
    cfg_wr(5, SPG_A_MODE, 0);
    cfg_wr(5, SPG_A_PERIOD, 3);
    cfg_wr(5, SPG_A_WIDTH, 0);
    wait_drain(1, 300, "badch_drain");

    // Sweep base 100, MINP 40, STEP 20
    cfg_wr(0, SPG_A_MODE, 0);
    cfg_wr(0, SPG_A_PERIOD, 100);
    cfg_wr(0, SPG_A_MINP, 40);
    cfg_wr(0, SPG_A_STEP, 20);
    sync_gen[0]++;
    @(negedge clk);
    push(0, 10, 101, 1);
    push(0, 10, 81, 1);
    push(0, 10, 61, 1);
    push(0, 10, 41, 1);
    push(0, 10, 61, 1);
    push(0, 10, 81, 1);
    push(0, 10, 101, 1);
    push(0, 10, 81, 1);
    cfg_wr(0, SPG_A_MODE, 2);
    repeat (200) @(negedge clk);
    chk("sweep_dir_down", sweep_dir[0], 1'b1);
    repeat (50) @(negedge clk);
    chk("sweep_dir_up", sweep_dir[0], 1'b0);
    repeat (180) @(negedge clk);
    chk("sweep_dir_down2", sweep_dir[0], 1'b1);
    wait_drain(0, 400, "sweep_drain");

    // Reset mid-sweep with a pending shadow write
    cfg_wr(0, SPG_A_PERIOD, 50);
    repeat (70) @(negedge clk);
    chk("pre_rst_dir", sweep_dir[0], 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_npulse", nPulse, 2'b11);
    chk("mid_rst_shot_done", shot_done, 2'b00);
    chk("mid_rst_sweep_dir", sweep_dir, 2'b11);
    chk("mid_rst_led", pulse_led, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sync_gen[0]++;
    sync_gen[1]++;
    push(0, 27, 4942, 1);
    push(1, 52, 7681, 1);
    @(negedge clk);
    chk("post_rst_first_low", nPulse, 2'b00);
    repeat (26) @(negedge clk);
    chk("post_rst_ch0_last_low", nPulse[0], 1'b0);
    @(negedge clk);
    chk("post_rst_ch0_high", nPulse[0], 1'b1);
    wait_drain(1, 8000, "post_rst_ch1_drain");
    wait_drain(0, 10, "post_rst_ch0_drain");

    // Single shot and retrigger
    cfg_wr(0, SPG_A_MODE, 0);
    cfg_wr(0, SPG_A_PERIOD, 9);
    cfg_wr(0, SPG_A_WIDTH, 2);
    shot_run("shot1");
    shot_run("shot2");

    // WIDTH beyond period leaves one idle cycle
    cfg_wr(0, SPG_A_PERIOD, 10);
    cfg_wr(0, SPG_A_WIDTH, 50);
    sync_gen[0]++;
    @(negedge clk);
    push(0, 10, 11, 3);
    cfg_wr(0, SPG_A_MODE, 1);
    wait_drain(0, 100, "wide_drain");

    // Zero period keeps the output idle
    cfg_wr(0, SPG_A_PERIOD, 0);
    cfg_wr(0, SPG_A_MODE, 1);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (nPulse[0] !== 1'b1) lows++;
    end
    chk("p0_lows", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
